// File: rtl/inst_fetch_bridge_if.sv
`default_nettype none
// ============================================================================
// inst_fetch_bridge_if : instruction-memory req/ack bus (bridge = master)
// Revision 1.0
// ============================================================================
interface inst_fetch_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_bridge.sv
`default_nettype none
// ============================================================================
// inst_fetch_bridge : IF-stage bridge with one-entry tagged instruction buffer
// Revision 1.0
// ============================================================================
module inst_fetch_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                flush,
    output logic [DATA_W-1:0]   inst_o,
    output logic                inst_valid_o,
    output logic                stallreq_o,
    inst_fetch_bridge_if.master mem
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                buf_valid_q;
    logic [ADDR_W-1:2]   buf_tag_q;
    logic [DATA_W-1:0]   buf_data_q;
    logic [ADDR_W-1:2]   req_tag_q;
    logic                discard_q;

    logic [ADDR_W-1:2]   w_pc_tag;
    logic                w_hit;
    logic                unused_pc_lsb;

    // Byte offset within the word never affects which word is fetched.
    assign w_pc_tag      = pc_i[ADDR_W-1:2];
    assign unused_pc_lsb = ^pc_i[1:0];

    assign w_hit        = ce_i & buf_valid_q & (buf_tag_q == w_pc_tag) & ~flush;
    assign inst_o       = w_hit ? buf_data_q : '0;
    assign inst_valid_o = w_hit;
    assign stallreq_o   = ce_i & ~w_hit & ~flush;

    assign mem.mem_req_o  = mem_req_q;
    assign mem.mem_addr_o = mem_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            req_tag_q   <= '0;
            discard_q   <= 1'b0;
        end else begin
            if (flush) begin
                buf_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ce_i && !w_hit && !flush) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {w_pc_tag, 2'b00};
                        req_tag_q  <= w_pc_tag;
                        discard_q  <= 1'b0;
                        state_q    <= ST_WAIT;
                    end else begin
                        mem_req_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A flushed request stays on the bus; only its data is dropped.
                    if (flush) begin
                        discard_q <= 1'b1;
                    end
                    if (mem.mem_ack_i) begin
                        if (!discard_q && !flush) begin
                            buf_valid_q <= 1'b1;
                            buf_tag_q   <= req_tag_q;
                            buf_data_q  <= mem.mem_rdata_i;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_bridge.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_bridge : self-checking bench with transaction-level model
// Revision 1.0
// ============================================================================
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stallreq;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;

    inst_fetch_bridge_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();
    assign mem_if.mem_ack_i   = ack;
    assign mem_if.mem_rdata_i = rdata;

    inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce),
        .pc_i         (pc),
        .flush        (flush),
        .inst_o       (inst),
        .inst_valid_o (inst_valid),
        .stallreq_o   (stallreq),
        .mem          (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: buffered word plus at most one outstanding fetch.
    logic        m_valid = 1'b0;
    logic [29:0] m_btag = '0;
    logic [31:0] m_bdata = '0;
    logic        m_pend = 1'b0;
    logic [29:0] m_ptag = '0;
    logic        m_drop = 1'b0;
    int          lat = 0;
    int          wcnt = 0;
    logic        stray = 1'b0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:2] == 30'h40) return 32'h24020005;
        w = {a[31:2], 2'b01} * 32'h9E3779B1;
        return w ^ 32'h5A5A0F0F;
    endfunction

    // Apply the edge to the model, clock the DUT, then play the memory side.
    task automatic step();
        logic hit;
        hit = ce && !flush && m_valid && (m_btag == pc[31:2]);
        if (rst) begin
            m_valid = 1'b0; m_btag = '0; m_bdata = '0;
            m_pend = 1'b0; m_ptag = '0; m_drop = 1'b0;
        end else begin
            if (m_pend) begin
                if (ack) begin
                    if (!m_drop && !flush) begin
                        m_valid = 1'b1; m_btag = m_ptag; m_bdata = rdata;
                    end
                    m_pend = 1'b0;
                end else if (flush) begin
                    m_drop = 1'b1;
                end
            end else if (ce && !hit && !flush) begin
                m_pend = 1'b1; m_ptag = pc[31:2]; m_drop = 1'b0;
            end
            if (flush) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (m_pend) begin
            ack = (wcnt >= lat);
            wcnt++;
            if (ack) rdata = m_drop ? 32'hDEADBEEF : memword({m_ptag, 2'b00});
            else     rdata = $urandom;
        end else begin
            wcnt  = 0;
            ack   = stray;
            rdata = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; pc = 32'h0; flush = 1'b0; lat = 0; stray = 1'b0;
        step(); #1;
        checks++; if (mem_if.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_if.mem_req_o); end
        checks++; if (mem_if.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_if.mem_addr_o); end
        checks++; if (inst !== 32'h0 || inst_valid !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL reset_outs got inst=%h v=%b s=%b exp 0/0/0", inst, inst_valid, stallreq); end
        ce = 1'b1;
        step();
        rst = 1'b0; #1;
        checks++; if (mem_if.mem_req_o !== 1'b0 || inst !== 32'h0 || stallreq !== 1'b1) begin errors++; $display("FAIL post_reset got req=%b inst=%h s=%b exp 0/0/1", mem_if.mem_req_o, inst, stallreq); end
        step(); #1;
        checks++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h exp 1/0", mem_if.mem_req_o, mem_if.mem_addr_o); end
        step(); #1;
        checks++; if (inst_valid !== 1'b1 || inst !== memword(32'h0)) begin errors++; $display("FAIL first_hit got v=%b inst=%h exp 1/%h", inst_valid, inst, memword(32'h0)); end
    endtask

    task automatic test_zero_wait();
        int n;
        lat = 0; pc = 32'h100; #1;
        n = 0;
        while (stallreq === 1'b1 && n < 10) begin n++; step(); #1; end
        checks++; if (n != 2) begin errors++; $display("FAIL zw_stall_cycles got %0d exp 2", n); end
        checks++; if (inst !== 32'h24020005 || inst_valid !== 1'b1 || stallreq !== 1'b0) begin errors++; $display("FAIL zw_hit got inst=%h v=%b s=%b exp 24020005/1/0", inst, inst_valid, stallreq); end
    endtask

    task automatic test_wait_states();
        int n;
        lat = 3; pc = 32'h108; #1;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL ws_miss got s=%b exp 1", stallreq); end
        step(); #1;
        n = 0;
        while (mem_if.mem_req_o === 1'b1 && n < 12) begin
            checks++; if (mem_if.mem_addr_o !== 32'h108) begin errors++; $display("FAIL ws_addr_stable got %h exp 00000108", mem_if.mem_addr_o); end
            n++; step(); #1;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL ws_req_cycles got %0d exp 4", n); end
        checks++; if (inst_valid !== 1'b1 || inst !== memword(32'h108)) begin errors++; $display("FAIL ws_hit got v=%b inst=%h exp 1/%h", inst_valid, inst, memword(32'h108)); end
    endtask

    task automatic test_flush_wait();
        int n;
        lat = 2; pc = 32'h200; #1;
        step(); #1;
        flush = 1'b1; pc = 32'h180; #1;
        checks++; if (stallreq !== 1'b0 || mem_if.mem_req_o !== 1'b1) begin errors++; $display("FAIL fl_cycle got s=%b req=%b exp 0/1", stallreq, mem_if.mem_req_o); end
        step();
        flush = 1'b0; #1;
        checks++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h200) begin errors++; $display("FAIL fl_held got req=%b addr=%h exp 1/00000200", mem_if.mem_req_o, mem_if.mem_addr_o); end
        step(); #1;
        checks++; if (ack !== 1'b1 || mem_if.mem_addr_o !== 32'h200 || inst === 32'hDEADBEEF) begin errors++; $display("FAIL fl_ack_cycle got ack=%b addr=%h inst=%h exp 1/00000200/not deadbeef", ack, mem_if.mem_addr_o, inst); end
        step(); #1;
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || stallreq !== 1'b1 || mem_if.mem_req_o !== 1'b0) begin errors++; $display("FAIL fl_dropped got v=%b inst=%h s=%b req=%b exp 0/0/1/0", inst_valid, inst, stallreq, mem_if.mem_req_o); end
        step(); #1;
        checks++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h180) begin errors++; $display("FAIL fl_newreq got req=%b addr=%h exp 1/00000180", mem_if.mem_req_o, mem_if.mem_addr_o); end
        n = 0;
        while (inst_valid !== 1'b1 && n < 10) begin
            checks++; if (inst === 32'hDEADBEEF) begin errors++; $display("FAIL fl_leak got %h exp not deadbeef", inst); end
            n++; step(); #1;
        end
        checks++; if (inst_valid !== 1'b1 || inst !== memword(32'h180)) begin errors++; $display("FAIL fl_hit got v=%b inst=%h exp 1/%h", inst_valid, inst, memword(32'h180)); end
    endtask

    task automatic test_branch();
        int n;
        lat = 0; pc = 32'h104; #1;
        n = 0;
        while (inst_valid !== 1'b1 && n < 10) begin n++; step(); #1; end
        checks++; if (inst_valid !== 1'b1 || inst !== memword(32'h104)) begin errors++; $display("FAIL br_hit got v=%b inst=%h exp 1/%h", inst_valid, inst, memword(32'h104)); end
        step(); #1;
        checks++; if (inst_valid !== 1'b1 || inst !== memword(32'h104) || mem_if.mem_req_o !== 1'b0) begin errors++; $display("FAIL br_hold got v=%b inst=%h req=%b exp 1/%h/0", inst_valid, inst, mem_if.mem_req_o, memword(32'h104)); end
        pc = 32'h400; #1;
        checks++; if (inst_valid !== 1'b0 || stallreq !== 1'b1 || inst !== 32'h0) begin errors++; $display("FAIL br_miss got v=%b s=%b inst=%h exp 0/1/0", inst_valid, stallreq, inst); end
        step(); #1;
        checks++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h400) begin errors++; $display("FAIL br_req got req=%b addr=%h exp 1/00000400", mem_if.mem_req_o, mem_if.mem_addr_o); end
        step(); #1;
        checks++; if (inst_valid !== 1'b1 || inst !== memword(32'h400)) begin errors++; $display("FAIL br_newhit got v=%b inst=%h exp 1/%h", inst_valid, inst, memword(32'h400)); end
    endtask

    task automatic test_stray_ack();
        ce = 1'b0; #1;
        checks++; if (inst !== 32'h0 || stallreq !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL ce0_outs got inst=%h s=%b v=%b exp 0/0/0", inst, stallreq, inst_valid); end
        ack = 1'b1; rdata = 32'hCAFEF00D;
        step(); #1;
        checks++; if (mem_if.mem_req_o !== 1'b0 || inst !== 32'h0) begin errors++; $display("FAIL stray_noreq got req=%b inst=%h exp 0/0", mem_if.mem_req_o, inst); end
        ce = 1'b1; #1;
        checks++; if (inst_valid !== 1'b1 || inst !== memword(32'h400)) begin errors++; $display("FAIL stray_nobuf got v=%b inst=%h exp 1/%h", inst_valid, inst, memword(32'h400)); end
    endtask

    task automatic test_random();
        logic exp_hit;
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 79) == 0);
            ce    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 2) == 0)
                pc = 32'h1000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
            lat   = $urandom_range(0, 3);
            stray = ($urandom_range(0, 3) == 0);
            #1;
            exp_hit = ce && !flush && m_valid && (m_btag == pc[31:2]);
            checks++; if (inst_valid !== exp_hit) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, inst_valid, exp_hit); end
            checks++; if (inst !== (exp_hit ? m_bdata : 32'h0)) begin errors++; $display("FAIL rnd_inst cyc %0d got %h exp %h", i, inst, exp_hit ? m_bdata : 32'h0); end
            checks++; if (stallreq !== (ce && !exp_hit && !flush)) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", i, stallreq, ce && !exp_hit && !flush); end
            checks++; if (mem_if.mem_req_o !== m_pend) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, mem_if.mem_req_o, m_pend); end
            if (m_pend) begin
                checks++; if (mem_if.mem_addr_o !== {m_ptag, 2'b00}) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, mem_if.mem_addr_o, {m_ptag, 2'b00}); end
            end
            checks++; if (inst === 32'hDEADBEEF) begin errors++; $display("FAIL rnd_leak cyc %0d got %h exp not deadbeef", i, inst); end
            step();
        end
        rst = 1'b0; flush = 1'b0; stray = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_flush_wait();
        test_branch();
        test_stray_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Instruction-side bus bridge between the `pc` stage and a variable-latency instruction memory. It accepts the fetch address and chip-enable from `pc`, runs a req/ack transaction on the memory bus, and holds the returned word in a one-entry tagged buffer. While the word for the current PC is not yet available, it raises a stall request to `ctrl`. It sits at the IF stage, feeding the IF/ID pipeline register.

## Interface
Parameters
- ADDR_W, 32, fetch address width (matches `InstAddrBus`)
- DATA_W, 32, instruction width (matches `InstBus`)

Ports
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ce_i  in  1  fetch enable from `pc`; 0 = PC held at reset/zero, no fetch
- pc_i  in  ADDR_W  current fetch address from `pc`
- flush  in  1  pipeline flush (exception/eret); invalidates buffer and in-flight data
- inst_o  out  DATA_W  instruction for IF/ID; 0 (NOP) when not a hit
- inst_valid_o  out  1  inst_o holds the word for pc_i
- stallreq_o  out  1  to `ctrl`; requests stall[0] while the fetch is outstanding
- mem_req_o  out  1  memory request, held until acknowledged
- mem_addr_o  out  ADDR_W  word-aligned request address {addr[31:2],2'b00}
- mem_ack_i  in  1  memory accepts and returns data this cycle
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i=1

## Operation
- Buffer: buf_valid, buf_tag[ADDR_W-1:2], buf_data.
- hit = ce_i & buf_valid & (buf_tag == pc_i[31:2]) & ~flush.
- Combinational outputs:
  - inst_o = hit ? buf_data : 0
  - inst_valid_o = hit
  - stallreq_o = ce_i & ~hit & ~flush
- FSM states: IDLE, WAIT.
  - IDLE, with ce_i=1, ~hit, ~flush: at the edge, set mem_req_o=1 and mem_addr_o={pc_i[31:2],2'b00}; latch req_tag=pc_i[31:2] and discard=0; go to WAIT.
  - IDLE otherwise: mem_req_o=0.
  - WAIT: mem_req_o and mem_addr_o are held stable until mem_ack_i=1.
    - On ack with discard=0 and no flush that cycle: buf_data=mem_rdata_i, buf_tag=req_tag, buf_valid=1.
    - On ack in any case: mem_req_o=0 and the FSM returns to IDLE.
- flush:
  - At the edge, buf_valid is cleared.
  - In WAIT, discard is set. The request is not withdrawn; its ack is consumed and its data is dropped.
  - The new PC misses in the following IDLE cycle.
- A PC change without flush (branch or sequential advance) needs no special handling; the tag mismatch forces a new fetch.
- mem_ack_i while mem_req_o=0 is ignored.
- ce_i=0: no new request is issued, stallreq_o=0, inst_o=0. An in-flight WAIT still completes normally.
- stall[] from `ctrl` is not an input. A held PC keeps hitting on the buffered word, so the outputs stay stable.

## Timing
- Reset values at the first edge with rst=1, regardless of state:
  - state=IDLE, mem_req_o=0, mem_addr_o=0, buf_valid=0, buf_tag=0, buf_data=0, discard=0
  - with ce_i=0: inst_o=0, inst_valid_o=0, stallreq_o=0
- Reset during WAIT drops mem_req_o on the next edge. The memory model must tolerate an abandoned request.
- Miss timeline, with the miss presented in cycle N and a zero-wait memory acking the first cycle it sees mem_req_o:
  - N: stallreq_o=1
  - N+1: mem_req_o=1 and mem_ack_i=1
  - N+2: hit, stallreq_o=0, instruction valid
  - `pc` advances at the end of N+2
- Steady sequential fetch costs 3 cycles per instruction with zero-wait memory. Each wait state adds 1 cycle.
- Flush in the same cycle as ack: the data is discarded and buf_valid=0 after the edge.
- Flush in the same cycle as an IDLE miss: no request is issued that edge.

## Test plan
- Reset: hold rst 2 cycles with ce_i=1 and pc_i=0. Required: mem_req_o=0, inst_o=0, stallreq_o=1 in the first post-reset cycle; mem_req_o=1 with mem_addr_o=0 in the next.
- Zero-wait fetch: pc_i=0x100, memory returns 0x24020005. Required: stallreq_o high 2 cycles, then inst_o=0x24020005, inst_valid_o=1, stallreq_o=0.
- Wait states: ack delayed 3 cycles. Required: mem_req_o and mem_addr_o stable for 4 cycles; hit one cycle after ack.
- Flush during WAIT: fetch 0x200 pending, flush=1 with pc_i changing to 0x180, ack 2 cycles later with 0xDEADBEEF. Required: buffer not written; a new request for 0x180 is issued after that ack; inst_o never shows 0xDEADBEEF.
- Branch: hit at 0x104, then pc_i=0x400. Required: inst_valid_o=0 and stallreq_o=1 immediately; request for 0x400 issued next cycle.
- Stray ack and ce_i=0: pulse mem_ack_i while IDLE with ce_i=0. Required: no buffer update, no request, inst_o=0.
